// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one operation at a time to the external 32-bit
// ripple ALU, captures its result and flags, and returns them on a
// valid/ready response channel.
// Optional feature macro: ALU_SEQ_MULT_EN builds the iterative unsigned
// multiply (op 1000). Without it op 1000 is answered as an illegal op.
module alu_op_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_sel1,
    output logic             alu_sel0,
    output logic             alu_binv,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_co,
    input  logic             alu_ovr,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [WIDTH-1:0] rsp_hi,
    output logic             rsp_zero,
    output logic             rsp_ovr,
    output logic             rsp_err
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;

`ifdef ALU_SEQ_MULT_EN
    localparam int CNT_W = $clog2(WIDTH);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP, S_MUL} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
`endif

    state_t           state_q, state_d;
    logic             ready_q, ready_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;          // operand A; multiplier / low product word during MUL
    logic [WIDTH-1:0] b_q, b_d;          // operand B; multiplicand during MUL
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic [WIDTH-1:0] rsp_hi_q, rsp_hi_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_ovr_q, rsp_ovr_d;
    logic             rsp_err_q, rsp_err_d;
    logic [WIDTH-1:0] exec_res;
    logic [3:0]       alu_ctl;
`ifdef ALU_SEQ_MULT_EN
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic             unused_co;
    assign unused_co = alu_co;
`endif

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: return 1'b1;
`ifdef ALU_SEQ_MULT_EN
            OP_MULTU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // {sel1, sel0, binv, cin} for each single-cycle op
    function automatic logic [3:0] ctrl_for_op(input logic [3:0] op);
        case (op)
            OP_OR:   return 4'b0100;
            OP_ADD:  return 4'b1000;
            OP_SUB:  return 4'b1011;
            OP_SLT:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    assign {alu_sel1, alu_sel0, alu_binv, alu_cin} = alu_ctl;
    assign req_ready  = ready_q;
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_result = rsp_result_q;
    assign rsp_hi     = rsp_hi_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_ovr    = rsp_ovr_q;
    assign rsp_err    = rsp_err_q;

    // Drive the ALU operand and control lines from the current state only
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_ctl = 4'b0000;
        case (state_q)
            S_EXEC: begin
                alu_a   = a_q;
                alu_b   = b_q;
                alu_ctl = ctrl_for_op(op_q);
            end
`ifdef ALU_SEQ_MULT_EN
            S_MUL: begin
                alu_a   = hi_q;
                alu_b   = a_q[0] ? b_q : '0;
                alu_ctl = 4'b1000;
            end
`endif
            default: ;
        endcase
    end

    // Next-state, operand latching and response capture
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_result_d = rsp_result_q;
        rsp_hi_d     = rsp_hi_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_ovr_d    = rsp_ovr_q;
        rsp_err_d    = rsp_err_q;
        exec_res     = '0;
`ifdef ALU_SEQ_MULT_EN
        hi_d         = hi_q;
        cnt_d        = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid && ready_q) begin
                    op_d = req_op;
                    a_d  = req_a;
                    b_d  = req_b;
`ifdef ALU_SEQ_MULT_EN
                    hi_d  = '0;
                    cnt_d = '0;
`endif
                    if (!is_legal(req_op)) begin
                        state_d      = S_RESP;
                        rsp_result_d = '0;
                        rsp_hi_d     = '0;
                        rsp_zero_d   = 1'b0;
                        rsp_ovr_d    = 1'b0;
                        rsp_err_d    = 1'b1;
                    end
`ifdef ALU_SEQ_MULT_EN
                    else if (req_op == OP_MULTU) begin
                        state_d = S_MUL;
                    end
`endif
                    else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                // SLT only carries its set bit in bit 0; upper ALU bits are noise
                exec_res     = (op_q == OP_SLT) ? {{(WIDTH-1){1'b0}}, alu_result[0]} : alu_result;
                rsp_result_d = exec_res;
                rsp_hi_d     = '0;
                rsp_zero_d   = (exec_res == '0);
                rsp_ovr_d    = ((op_q == OP_ADD) || (op_q == OP_SUB)) ? alu_ovr : 1'b0;
                rsp_err_d    = 1'b0;
                state_d      = S_RESP;
            end
`ifdef ALU_SEQ_MULT_EN
            S_MUL: begin
                // Shift-add step: the 33-bit sum shifts right into {hi, lo}
                hi_d  = {alu_co, alu_result[WIDTH-1:1]};
                a_d   = {alu_result[0], a_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    rsp_result_d = {alu_result[0], a_q[WIDTH-1:1]};
                    rsp_hi_d     = {alu_co, alu_result[WIDTH-1:1]};
                    rsp_zero_d   = ({alu_result[0], a_q[WIDTH-1:1]} == '0);
                    rsp_ovr_d    = 1'b0;
                    rsp_err_d    = 1'b0;
                    state_d      = S_RESP;
                end
            end
`endif
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    // Control and response registers; reset aborts any op in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ready_q      <= 1'b0;
            rsp_result_q <= '0;
            rsp_hi_q     <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_ovr_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
`ifdef ALU_SEQ_MULT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            rsp_result_q <= rsp_result_d;
            rsp_hi_q     <= rsp_hi_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_ovr_q    <= rsp_ovr_d;
            rsp_err_q    <= rsp_err_d;
`ifdef ALU_SEQ_MULT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    // Latched op and operand datapath registers
    always_ff @(posedge clk) begin
        op_q <= op_d;
        a_q  <= a_d;
        b_q  <= b_d;
`ifdef ALU_SEQ_MULT_EN
        hi_q <= hi_d;
`endif
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: behavioural ALU, transaction-level reference
// model and a per-cycle compare of all sequencer outputs.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a, req_b;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_sel1, alu_sel0, alu_binv, alu_cin, alu_co, alu_ovr;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result, rsp_hi;
    logic        rsp_zero, rsp_ovr, rsp_err;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b),
        .alu_sel1(alu_sel1), .alu_sel0(alu_sel0), .alu_binv(alu_binv), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_co(alu_co), .alu_ovr(alu_ovr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_hi(rsp_hi),
        .rsp_zero(rsp_zero), .rsp_ovr(rsp_ovr), .rsp_err(rsp_err)
    );

    // Behavioural ripple ALU; SLT leaves difference bits above bit 0
    always_comb begin
        logic [32:0] s;
        logic [31:0] bb;
        bb      = alu_binv ? ~alu_b : alu_b;
        s       = {1'b0, alu_a} + {1'b0, bb} + 33'(alu_cin);
        alu_co  = s[32];
        alu_ovr = (alu_a[31] == bb[31]) && (s[31] != alu_a[31]);
        case ({alu_sel1, alu_sel0})
            2'b00:   alu_result = alu_a & alu_b;
            2'b01:   alu_result = alu_a | alu_b;
            2'b10:   alu_result = s[31:0];
            default: alu_result = {s[31:1], ($signed(alu_a) < $signed(alu_b))};
        endcase
    end

    task automatic check(input string name, input logic [136:0] act, input logic [136:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected response of one request, straight from the op definitions
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic [31:0] h,
                         output logic z, output logic o, output logic e, output int lat);
        logic [63:0] p;
        r = 0; h = 0; o = 0; e = 0; lat = 2;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
            4'b0110: begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef ALU_SEQ_MULT_EN
            4'b1000: begin p = 64'(a) * 64'(b); h = p[63:32]; r = p[31:0]; lat = 33; end
`endif
            default: begin e = 1; lat = 1; end
        endcase
        z = !e && (r == 0);
    endtask

    function automatic logic [3:0] ctl_of(input logic [3:0] op);
        case (op)
            4'b0001: return 4'b0100;
            4'b0010: return 4'b1000;
            4'b0110: return 4'b1011;
            4'b0111: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Accumulator seen by the ALU before multiply step k: floor((a mod 2^k) * b / 2^k)
    function automatic logic [31:0] mul_partial(input logic [31:0] a, input logic [31:0] b, input int k);
        logic [63:0] m;
        m = (64'(a) & ((64'd1 << k) - 64'd1)) * 64'(b);
        return 32'(m >> k);
    endfunction

    // Reference model state, advanced on each rising edge
    int          cyc = 0;
    int          due = 0;
    bit          has_pend = 0, rdy_exp = 0, in_rst = 0;
    logic [3:0]  p_op;
    logic [31:0] p_a, p_b, p_r, p_h;
    logic        p_z, p_o, p_e;
    int          p_lat;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                has_pend = 0; rdy_exp = 0; in_rst = 1;
            end else begin
                in_rst = 0;
                if (has_pend) begin
                    if (cyc >= due && rsp_ready) begin has_pend = 0; rdy_exp = 1; end
                end else if (rdy_exp && req_valid) begin
                    model(req_op, req_a, req_b, p_r, p_h, p_z, p_o, p_e, p_lat);
                    p_op = req_op; p_a = req_a; p_b = req_b;
                    due = cyc + p_lat; has_pend = 1; rdy_exp = 0;
                end else begin
                    rdy_exp = 1;
                end
            end
            cyc++;
        end
    end

    // Per-cycle compare of handshake, ALU drive and response outputs
    initial begin
        logic        ev;
        logic [3:0]  ectl;
        logic [31:0] ea, eb;
        logic [66:0] efld, ofld;
        int          k;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                ev = has_pend && (cyc >= due);
                ectl = 0; ea = 0; eb = 0;
                if (has_pend && !ev) begin
                    if (p_lat == 2) begin
                        ectl = ctl_of(p_op); ea = p_a; eb = p_b;
                    end else if (p_lat == 33) begin
                        k = cyc - (due - 33) - 1;
                        ectl = 4'b1000; ea = mul_partial(p_a, p_b, k); eb = p_a[k] ? p_b : 32'd0;
                    end
                end
                efld = ev ? {p_r, p_h, p_z, p_o, p_e} : 67'd0;
                ofld = (ev || in_rst) ? {rsp_result, rsp_hi, rsp_zero, rsp_ovr, rsp_err} : 67'd0;
                check("cycle", {rsp_valid, req_ready, alu_sel1, alu_sel0, alu_binv, alu_cin, alu_a, alu_b, ofld},
                               {ev, rdy_exp, ectl, ea, eb, efld});
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int hold,
                         output logic [31:0] r, output logic [31:0] h, output logic [2:0] f, output int lat);
        int n;
        r = 0; h = 0; f = 0; lat = 0; n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        check("wait_ready", 137'(req_ready), 137'(1));
        req_valid = 1; req_op = op; req_a = a; req_b = b; rsp_ready = (hold == 0);
        @(negedge clk);
        req_valid = 0; req_op = 4'($urandom); req_a = $urandom; req_b = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 60) begin @(negedge clk); lat++; end
        check("wait_rsp", 137'(rsp_valid), 137'(1));
        r = rsp_result; h = rsp_hi; f = {rsp_zero, rsp_ovr, rsp_err};
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            rsp_ready = 1;
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 4))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] r, h, er, eh;
        logic [2:0]  f;
        logic        ez, eo, ee;
        logic [3:0]  op;
        logic [3:0]  ops [8];
        int          lat, elat, n;
        ops = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h8, 4'h3, 4'hF};

        rst_n = 0; req_valid = 0; req_op = 0; req_a = 0; req_b = 0; rsp_ready = 1;
        repeat (3) @(negedge clk);
        check("rst_ready", 137'(req_ready), 137'(0));
        check("rst_valid", 137'(rsp_valid), 137'(0));
        check("rst_outs", {alu_sel1, alu_sel0, alu_binv, alu_cin, alu_a, alu_b, rsp_result, rsp_hi, rsp_zero, rsp_ovr, rsp_err}, 137'(0));
        rst_n = 1;
        @(negedge clk);
        check("ready_after_rst", 137'(req_ready), 137'(1));

        issue(4'b0010, 32'd7, 32'd5, 0, r, h, f, lat);
        check("add_res", 137'(r), 137'(12));
        check("add_flags", 137'(f), 137'(3'b000));
        check("add_lat", 137'(lat), 137'(2));
        issue(4'b0110, 32'h8000_0000, 32'd1, 0, r, h, f, lat);
        check("sub_ovr_res", 137'(r), 137'(32'h7FFF_FFFF));
        check("sub_ovr_flags", 137'(f), 137'(3'b010));
        issue(4'b0110, 32'd9, 32'd9, 0, r, h, f, lat);
        check("sub_zero", {r, f}, {32'd0, 3'b100});
        issue(4'b0111, 32'hFFFF_FFFD, 32'd2, 0, r, h, f, lat);
        check("slt_lt", {r, f}, {32'd1, 3'b000});
        issue(4'b0111, 32'd2, 32'hFFFF_FFFD, 0, r, h, f, lat);
        check("slt_ge", {r, f}, {32'd0, 3'b100});
        issue(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, r, h, f, lat);
`ifdef ALU_SEQ_MULT_EN
        check("multu_max", {h, r, f}, {32'hFFFF_FFFE, 32'h0000_0001, 3'b000});
        check("multu_lat", 137'(lat), 137'(33));
`else
        check("multu_illegal", {h, r, f}, {64'd0, 3'b001});
        check("multu_lat", 137'(lat), 137'(1));
`endif
        issue(4'b0001, 32'h0000_1234, 32'h0000_00F0, 5, r, h, f, lat);
        check("or_hold", {r, f}, {32'h0000_12F4, 3'b000});
        issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 0, r, h, f, lat);
        check("illegal", {h, r, f}, {64'd0, 3'b001});
        check("illegal_lat", 137'(lat), 137'(1));

        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom) : ops[$urandom_range(0, 7)];
            req_a = rnd_word(); req_b = rnd_word();
            model(op, req_a, req_b, er, eh, ez, eo, ee, elat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(op, req_a, req_b, $urandom_range(0, 3), r, h, f, lat);
            check("rand_rsp", {h, r, f, 32'(lat)}, {eh, er, ez, eo, ee, 32'(elat)});
        end

        // Abort a multiply at step 10, then run a plain AND right after release
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        req_valid = 1; req_op = 4'b1000; req_a = 32'hFFFF_FFFF; req_b = 32'd3;
        @(negedge clk);
        req_valid = 0;
        repeat (10) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        check("abort_ready", 137'(req_ready), 137'(0));
        check("abort_valid", 137'(rsp_valid), 137'(0));
        rst_n = 1;
        @(negedge clk);
        issue(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 0, r, h, f, lat);
        check("and_after_abort", {r, f}, {32'h0000_F000, 3'b000});

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
